// File: rtl/pr_hrav_disp_pkg.sv
// Shared types and helpers for the HRAV packet dispatcher.
//   disp_state_e : packet-level FSM state
//   rr_pick      : round-robin search returning {found, idx}
//   dst_icap     : destination index used for the ICAP path
package pr_hrav_disp_pkg;

    localparam int C_MAX_CORES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } disp_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // ICAP sits one past the last core.
    function automatic int dst_icap(input int num_cores);
        return num_cores;
    endfunction

    // First enabled core at index >= ptr, wrapping modulo n. The loop runs
    // downward so the lowest offset from ptr is the one that sticks.
    function automatic rr_pick_t rr_pick(input logic [C_MAX_CORES-1:0] enb,
                                         input logic [3:0]             ptr,
                                         input int                     n);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int i = C_MAX_CORES - 1; i >= 0; i--) begin
            if (i < n) begin
                c = (int'(ptr) + i) % n;
                if (enb[c[3:0]]) begin
                    r.found = 1'b1;
                    r.idx   = c[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pr_hrav_axis_reg.sv
// One-stage AXI-Stream pipeline register carrying a destination tag.
//   load            : capture in_* this cycle (caller guarantees in_ready)
//   in_ready        : register empty or its destination is taking the beat
//   m_valid[ND]     : one-hot valid toward the tagged destination
//   m_ready[ND]     : per-destination ready; only the tagged bit is used
//   m_data/strb/... : registered payload, broadcast
module pr_hrav_axis_reg #(
    parameter int W  = 256,
    parameter int U  = 128,
    parameter int ND = 5,
    parameter int DW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [W-1:0]    in_data,
    input  logic [W/8-1:0]  in_strb,
    input  logic [U-1:0]    in_user,
    input  logic            in_last,
    input  logic [DW-1:0]   in_dst,
    output logic            in_ready,
    input  logic [ND-1:0]   m_ready,
    output logic [W-1:0]    m_data,
    output logic [W/8-1:0]  m_strb,
    output logic [U-1:0]    m_user,
    output logic            m_last,
    output logic [ND-1:0]   m_valid
);

    logic          valid_q;
    logic [DW-1:0] dst_q;

    assign in_ready = !valid_q || m_ready[dst_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dst_q   <= '0;
            m_data  <= '0;
            m_strb  <= '0;
            m_user  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            // Covers the same-cycle egress+ingress case: contents are
            // simply replaced, no bubble.
            valid_q <= 1'b1;
            dst_q   <= in_dst;
            m_data  <= in_data;
            m_strb  <= in_strb;
            m_user  <= in_user;
            m_last  <= in_last;
        end else if (valid_q && m_ready[dst_q]) begin
            valid_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < ND; i++) begin : g_vld
        assign m_valid[i] = valid_q && (dst_q == DW'(i));
    end

endmodule

// File: rtl/pr_hrav_dispatcher_n.sv
// N-core packet dispatcher: whole packets go to ICAP (TUSER[C_ICAP_BIT] on
// the head beat) or round-robin over enabled cores; packets with nowhere
// to go are swallowed and counted.
//   ACLK/ARESET      : clock, synchronous active-high reset
//   core_enb         : per-core enable, sampled on the head beat only
//   S_AXIS_*         : ingress stream
//   M_AXIS_*         : egress payload (broadcast) + one-hot TVALID/TREADY
//   drop_cnt         : saturating dropped-packet count
//   rr_ptr           : next round-robin candidate
module pr_hrav_dispatcher_n
    import pr_hrav_disp_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_CORES        = 4,
    parameter int C_ICAP_BIT         = 32,
    localparam int PW = (C_NUM_CORES > 1) ? $clog2(C_NUM_CORES) : 1
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_NUM_CORES-1:0]          core_enb,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                            S_AXIS_TLAST,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                            M_AXIS_TLAST,
    output logic [C_NUM_CORES:0]            M_AXIS_TVALID,
    input  logic [C_NUM_CORES:0]            M_AXIS_TREADY,
    output logic [31:0]                     drop_cnt,
    output logic [PW-1:0]                   rr_ptr
);

    localparam int ND         = C_NUM_CORES + 1;
    localparam int DW         = $clog2(ND);
    localparam int C_DST_ICAP = dst_icap(C_NUM_CORES);

    disp_state_e   state_q, state_d;
    logic [PW-1:0] rr_q, rr_adv;
    logic [DW-1:0] dst_q, head_dst, cur_dst;
    logic [31:0]   drop_q;

    logic [C_MAX_CORES-1:0] enb16;
    logic [3:0]             ptr4;
    rr_pick_t               pick;

    logic head, icap, head_drop, dropping, out_ready, s_ready, accept, load;

    // Routing decision, evaluated combinationally on the head beat.
    always_comb begin
        enb16                  = '0;
        enb16[C_NUM_CORES-1:0] = core_enb;
        ptr4                   = '0;
        ptr4[PW-1:0]           = rr_q;
        pick                   = rr_pick(enb16, ptr4, C_NUM_CORES);
        rr_adv                 = (pick.idx == 4'(C_NUM_CORES - 1)) ? '0
                                                                  : PW'(pick.idx + 4'd1);
        head      = (state_q == IDLE);
        icap      = S_AXIS_TUSER[C_ICAP_BIT];
        head_drop = head && !icap && !pick.found;
        head_dst  = icap ? DW'(C_DST_ICAP) : DW'(pick.idx);
        cur_dst   = head ? head_dst : dst_q;
        // Dropped beats bypass the output register, so they never stall.
        dropping  = (state_q == DROP) || head_drop;
        s_ready   = dropping || out_ready;
        accept    = S_AXIS_TVALID && s_ready;
        load      = accept && !dropping;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (S_AXIS_TLAST)
                state_d = IDLE;
            else if (head)
                state_d = head_drop ? DROP : FWD;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            rr_q    <= '0;
            dst_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept && head) begin
                dst_q <= head_dst;
                // ICAP packets leave the core rotation untouched.
                if (!icap && pick.found)
                    rr_q <= rr_adv;
                if (head_drop && drop_q != 32'hFFFF_FFFF)
                    drop_q <= drop_q + 32'd1;
            end
        end
    end

    pr_hrav_axis_reg #(
        .W  (C_AXIS_DATA_WIDTH),
        .U  (C_AXIS_TUSER_WIDTH),
        .ND (ND),
        .DW (DW)
    ) u_oreg (
        .clk      (ACLK),
        .rst      (ARESET),
        .load     (load),
        .in_data  (S_AXIS_TDATA),
        .in_strb  (S_AXIS_TSTRB),
        .in_user  (S_AXIS_TUSER),
        .in_last  (S_AXIS_TLAST),
        .in_dst   (cur_dst),
        .in_ready (out_ready),
        .m_ready  (M_AXIS_TREADY),
        .m_data   (M_AXIS_TDATA),
        .m_strb   (M_AXIS_TSTRB),
        .m_user   (M_AXIS_TUSER),
        .m_last   (M_AXIS_TLAST),
        .m_valid  (M_AXIS_TVALID)
    );

    assign S_AXIS_TREADY = s_ready;
    assign drop_cnt      = drop_q;
    assign rr_ptr        = rr_q;

endmodule

// File: tb/tb_pr_hrav_dispatcher_n.sv
module tb_pr_hrav_dispatcher_n;

    localparam int W  = 256;
    localparam int U  = 128;
    localparam int N  = 4;
    localparam int ND = N + 1;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic [N-1:0]   core_enb;
    logic [W-1:0]   S_AXIS_TDATA;
    logic [W/8-1:0] S_AXIS_TSTRB;
    logic [U-1:0]   S_AXIS_TUSER;
    logic           S_AXIS_TLAST;
    logic           S_AXIS_TVALID;
    logic           S_AXIS_TREADY;
    logic [W-1:0]   M_AXIS_TDATA;
    logic [W/8-1:0] M_AXIS_TSTRB;
    logic [U-1:0]   M_AXIS_TUSER;
    logic           M_AXIS_TLAST;
    logic [ND-1:0]  M_AXIS_TVALID;
    logic [ND-1:0]  M_AXIS_TREADY;
    logic [31:0]    drop_cnt;
    logic [1:0]     rr_ptr;

    logic [ND-1:0]  tready_man;
    logic [ND-1:0]  tready_rnd;
    logic           rnd_on;

    typedef struct packed {
        logic [ND-1:0] vld;
        logic [31:0]   d;
        logic          last;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] seq   = 32'h100;

    always #5 ACLK = ~ACLK;

    assign M_AXIS_TREADY = rnd_on ? tready_rnd : tready_man;

    pr_hrav_dispatcher_n #(
        .C_AXIS_DATA_WIDTH  (W),
        .C_AXIS_TUSER_WIDTH (U),
        .C_NUM_CORES        (N),
        .C_ICAP_BIT         (32)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .core_enb      (core_enb),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .drop_cnt      (drop_cnt),
        .rr_ptr        (rr_ptr)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: an egress handshake is visible at the negedge before the edge
    // that completes it; inputs are only changed just after posedges.
    always @(negedge ACLK) begin : mon
        exp_t        e;
        logic [31:0] es;
        if (|(M_AXIS_TVALID & M_AXIS_TREADY)) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", M_AXIS_TVALID, 0);
            end else begin
                e  = sb.pop_front();
                es = ~e.d;
                chk("dst",  M_AXIS_TVALID, e.vld);
                chk("data", M_AXIS_TDATA,  {8{e.d}});
                chk("strb", M_AXIS_TSTRB,  es);
                chk("last", M_AXIS_TLAST,  e.last);
            end
        end
    end

    always @(posedge ACLK) begin
        #1;
        tready_rnd = ND'($urandom);
    end

    task automatic drive(input logic [31:0] d, input logic icap, input logic last);
        S_AXIS_TDATA     = {8{d}};
        S_AXIS_TSTRB     = ~d;
        S_AXIS_TUSER     = '0;
        S_AXIS_TUSER[32] = icap;
        S_AXIS_TLAST     = last;
        S_AXIS_TVALID    = 1'b1;
    endtask

    // One beat; ev=0 means the beat is expected to be dropped.
    task automatic send(input logic icap, input logic last, input logic [ND-1:0] ev);
        int   n;
        logic rdy;
        exp_t x;
        if (ev != '0) begin
            x.vld  = ev;
            x.d    = seq;
            x.last = last;
            sb.push_back(x);
        end
        drive(seq, icap, last);
        seq++;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 200) begin
            @(negedge ACLK);
            rdy = S_AXIS_TREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        if (!rdy) chk("accept_timeout", 0, 1);
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic pkt(input int beats, input logic icap, input logic [ND-1:0] ev);
        for (int b = 0; b < beats; b++)
            send(icap && (b == 0), b == beats - 1, ev);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET        = 1'b1;
        core_enb      = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TLAST  = 1'b0;
        tready_man    = '1;
        rnd_on        = 1'b0;
        idle(3);
        ARESET = 1'b0;

        @(negedge ACLK);
        chk("rst_tvalid", M_AXIS_TVALID, 0);
        chk("rst_rr",     rr_ptr, 0);
        chk("rst_drop",   drop_cnt, 0);
        chk("rst_sready", S_AXIS_TREADY, 1);
        chk("rst_tdata",  M_AXIS_TDATA, 0);
        chk("rst_tlast",  M_AXIS_TLAST, 0);
        @(posedge ACLK);
        #1;

        // Round robin over all four cores.
        core_enb = 4'b1111;
        pkt(1, 0, 5'b00001);
        pkt(1, 0, 5'b00010);
        pkt(1, 0, 5'b00100);
        pkt(1, 0, 5'b01000);
        pkt(1, 0, 5'b00001);
        pkt(1, 0, 5'b00010);
        chk("rr_after_6", rr_ptr, 2);
        pkt(1, 0, 5'b00100);
        pkt(1, 0, 5'b01000);
        chk("rr_wrap", rr_ptr, 0);

        // Skip disabled cores; enable change mid-packet must not move dst.
        core_enb = 4'b0101;
        pkt(3, 0, 5'b00001);
        send(0, 0, 5'b00100);
        core_enb = 4'b0001;
        send(0, 0, 5'b00100);
        send(0, 1, 5'b00100);
        pkt(3, 0, 5'b00001);
        chk("rr_skip", rr_ptr, 1);

        // ICAP routing with rr_ptr=3.
        core_enb = 4'b1111;
        pkt(1, 0, 5'b00010);
        pkt(1, 0, 5'b00100);
        chk("rr_pre_icap", rr_ptr, 3);
        pkt(3, 1, 5'b10000);
        chk("rr_post_icap", rr_ptr, 3);
        idle(2);

        // Drop with no cores enabled.
        core_enb = 4'b0000;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 4; b++) begin
                drive(seq, 0, b == 3);
                seq++;
                @(negedge ACLK);
                chk("drop_sready", S_AXIS_TREADY, 1);
                chk("drop_tvalid", M_AXIS_TVALID, 0);
                @(posedge ACLK);
                #1;
            end
        end
        S_AXIS_TVALID = 1'b0;
        chk("drop_cnt", drop_cnt, 2);
        chk("rr_drop",  rr_ptr, 3);

        // Backpressure on core 1; other ready bits stay high on purpose.
        core_enb = 4'b1111;
        pkt(1, 0, 5'b01000);
        pkt(1, 0, 5'b00001);
        send(0, 0, 5'b00010);
        tready_man = 5'b11101;
        drive(seq, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            chk("bp_sready", S_AXIS_TREADY, 0);
            chk("bp_tvalid", M_AXIS_TVALID, 5'b00010);
            chk("bp_tdata",  M_AXIS_TDATA, {8{seq - 32'd1}});
            @(posedge ACLK);
            #1;
        end
        tready_man = '1;
        send(0, 0, 5'b00010);
        send(0, 0, 5'b00010);
        send(0, 1, 5'b00010);
        chk("rr_bp", rr_ptr, 2);

        // Random per-destination ready over 1000 packets.
        rnd_on = 1'b1;
        for (int k = 0; k < 1000; k++)
            pkt(1 + int'($urandom_range(0, 1)), 0, ND'(1 << ((2 + k) % 4)));
        rnd_on = 1'b0;
        idle(5);
        chk("rnd_drained", sb.size(), 0);
        chk("rr_rnd", rr_ptr, 2);

        // Reset on beat 2 of a 4-beat packet heading to core 2.
        send(0, 0, 5'b00100);
        send(0, 0, 5'b00100);
        drive(seq, 0, 0);
        seq++;
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET        = 1'b0;
        S_AXIS_TVALID = 1'b0;
        chk("rst2_tvalid", M_AXIS_TVALID, 0);
        chk("rst2_rr",     rr_ptr, 0);
        chk("rst2_drop",   drop_cnt, 0);
        pkt(4, 0, 5'b00001);
        chk("rr_after_rst", rr_ptr, 1);

        idle(3);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
